// File: rtl/apb_master.sv
// APB (v3-style) single-outstanding requester: valid/ready command port in,
// SETUP/ACCESS transfers out, one-cycle response strobe with PREADY timeout.
module apb_master #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 16
) (
    input  logic              PCLK,
    input  logic              PRESETn,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_write,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [DATA_W-1:0] cmd_wdata,
    output logic              rsp_valid,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_err,
    output logic              PSEL,
    output logic              PENABLE,
    output logic              PWRITE,
    output logic [ADDR_W-1:0] PADDR,
    output logic [DATA_W-1:0] PWDATA,
    input  logic [DATA_W-1:0] PRDATA,
    input  logic              PREADY
);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_SETUP  = 2'd1;
    localparam logic [1:0] S_ACCESS = 2'd2;
    localparam logic [1:0] S_ERR    = 2'd3;

    localparam bit          TO_EN   = (TIMEOUT != 0);
    localparam logic [15:0] TO_LAST = 16'(TIMEOUT - 1);
    localparam logic [15:0] CNT_MAX = 16'hFFFF;

    logic [1:0]        state_q,     state_d;
    logic              psel_q,      psel_d;
    logic              penable_q,   penable_d;
    logic              pwrite_q,    pwrite_d;
    logic [ADDR_W-1:0] paddr_q,     paddr_d;
    logic [DATA_W-1:0] pwdata_q,    pwdata_d;
    logic [15:0]       wait_cnt_q,  wait_cnt_d;
    logic              rsp_valid_q, rsp_valid_d;
    logic              rsp_err_q,   rsp_err_d;
    logic [DATA_W-1:0] rsp_rdata_q, rsp_rdata_d;

    logic accept;
    logic aligned;
    logic timed_out;

    assign cmd_ready = (state_q == S_IDLE);
    assign accept    = cmd_valid && cmd_ready;
    assign aligned   = (cmd_addr[1:0] == 2'b00);
    assign timed_out = TO_EN && (wait_cnt_q == TO_LAST);

    always_comb begin
        state_d     = state_q;
        psel_d      = psel_q;
        penable_d   = penable_q;
        pwrite_d    = pwrite_q;
        paddr_d     = paddr_q;
        pwdata_d    = pwdata_q;
        wait_cnt_d  = wait_cnt_q;
        rsp_valid_d = 1'b0;
        rsp_err_d   = rsp_err_q;
        rsp_rdata_d = rsp_rdata_q;

        unique case (state_q)
            S_IDLE: begin
                if (accept) begin
                    if (aligned) begin
                        pwrite_d   = cmd_write;
                        paddr_d    = cmd_addr;
                        pwdata_d   = cmd_wdata;
                        psel_d     = 1'b1;
                        penable_d  = 1'b0;
                        wait_cnt_d = '0;
                        state_d    = S_SETUP;
                    end else begin
                        state_d = S_ERR;
                    end
                end
            end
            S_SETUP: begin
                penable_d = 1'b1;
                state_d   = S_ACCESS;
            end
            S_ACCESS: begin
                if (PREADY) begin
                    psel_d      = 1'b0;
                    penable_d   = 1'b0;
                    state_d     = S_IDLE;
                    rsp_valid_d = 1'b1;
                    rsp_err_d   = 1'b0;
                    rsp_rdata_d = pwrite_q ? '0 : PRDATA;
                end else begin
                    // saturate so a disabled timeout can never wrap
                    if (wait_cnt_q != CNT_MAX) begin
                        wait_cnt_d = wait_cnt_q + 16'd1;
                    end
                    if (timed_out) begin
                        psel_d      = 1'b0;
                        penable_d   = 1'b0;
                        state_d     = S_IDLE;
                        rsp_valid_d = 1'b1;
                        rsp_err_d   = 1'b1;
                        rsp_rdata_d = '0;
                    end
                end
            end
            S_ERR: begin
                state_d     = S_IDLE;
                rsp_valid_d = 1'b1;
                rsp_err_d   = 1'b1;
                rsp_rdata_d = '0;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            state_q     <= S_IDLE;
            psel_q      <= 1'b0;
            penable_q   <= 1'b0;
            pwrite_q    <= 1'b0;
            paddr_q     <= '0;
            pwdata_q    <= '0;
            wait_cnt_q  <= '0;
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= 1'b0;
            rsp_rdata_q <= '0;
        end else begin
            state_q     <= state_d;
            psel_q      <= psel_d;
            penable_q   <= penable_d;
            pwrite_q    <= pwrite_d;
            paddr_q     <= paddr_d;
            pwdata_q    <= pwdata_d;
            wait_cnt_q  <= wait_cnt_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_err_q   <= rsp_err_d;
            rsp_rdata_q <= rsp_rdata_d;
        end
    end

    assign PSEL      = psel_q;
    assign PENABLE   = penable_q;
    assign PWRITE    = pwrite_q;
    assign PADDR     = paddr_q;
    assign PWDATA    = pwdata_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_err   = rsp_err_q;
    assign rsp_rdata = rsp_rdata_q;

    // protocol invariants of the APB side
    a_en_sel : assert property (@(posedge PCLK) disable iff (!PRESETn)
        PENABLE |-> PSEL);
    a_en_acc : assert property (@(posedge PCLK) disable iff (!PRESETn)
        PENABLE |-> (state_q == S_ACCESS));

endmodule

// File: tb/tb_apb_master.sv
// Directed bench for apb_master with a 4-register APB slave model
// (regs at 0x0/0x4/0x8/0xC, everything else reads 0).
module tb_apb_master;

    logic        PCLK = 1'b0;
    logic        PRESETn;
    logic        cmd_valid;
    logic        cmd_ready;
    logic        cmd_write;
    logic [31:0] cmd_addr;
    logic [31:0] cmd_wdata;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic        PSEL;
    logic        PENABLE;
    logic        PWRITE;
    logic [31:0] PADDR;
    logic [31:0] PWDATA;
    logic [31:0] PRDATA;
    logic        PREADY;
    logic        slv_ready;

    int n_vec = 0;
    int n_err = 0;

    always #5 PCLK = ~PCLK;

    apb_master #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(16)) dut (
        .PCLK(PCLK), .PRESETn(PRESETn),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_write(cmd_write), .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
        .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE),
        .PADDR(PADDR), .PWDATA(PWDATA), .PRDATA(PRDATA), .PREADY(PREADY)
    );

    logic [31:0] regs [4];
    logic        mapped;

    assign mapped = (PADDR < 32'h10);
    assign PREADY = slv_ready;
    assign PRDATA = (PSEL && mapped) ? regs[PADDR[3:2]] : 32'h0;

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            regs <= '{default: 32'h0};
        end else if (PSEL && PENABLE && PREADY && PWRITE && mapped) begin
            regs[PADDR[3:2]] <= PWDATA;
        end
    end

    // drive one command from a negedge in IDLE; return at the response negedge
    task automatic run_cmd(input logic w, input logic [31:0] a,
                           input logic [31:0] d, output logic [31:0] rd,
                           output logic er, output int n_sel,
                           output int n_en, output int lat);
        cmd_valid = 1'b1;
        cmd_write = w;
        cmd_addr  = a;
        cmd_wdata = d;
        @(posedge PCLK);
        @(negedge PCLK);
        cmd_valid = 1'b0;
        cmd_write = ~w;
        cmd_addr  = 32'h3;
        cmd_wdata = 32'hA5A5_A5A5;
        n_sel = 0;
        n_en  = 0;
        lat   = 1;
        while (!rsp_valid && lat < 100) begin
            if (PSEL) n_sel++;
            if (PENABLE) n_en++;
            @(negedge PCLK);
            lat++;
        end
        rd = rsp_rdata;
        er = rsp_err;
    endtask

    task automatic test_reset;
        PRESETn   = 1'b0;
        cmd_valid = 1'b0;
        cmd_write = 1'b0;
        cmd_addr  = 32'h0;
        cmd_wdata = 32'h0;
        slv_ready = 1'b1;
        #12;
        n_vec++;
        if (cmd_ready !== 1'b1) begin
            n_err++;
            $display("FAIL reset_cmd_ready: got %b want 1", cmd_ready);
        end
        n_vec++;
        if ({PSEL, PENABLE, PWRITE, rsp_valid, rsp_err} !== 5'b0) begin
            n_err++;
            $display("FAIL reset_ctl: got %b want 00000",
                     {PSEL, PENABLE, PWRITE, rsp_valid, rsp_err});
        end
        n_vec++;
        if ({PADDR, PWDATA, rsp_rdata} !== 96'h0) begin
            n_err++;
            $display("FAIL reset_data: got %h %h %h want 0",
                     PADDR, PWDATA, rsp_rdata);
        end
        @(negedge PCLK);
        PRESETn = 1'b1;
        @(negedge PCLK);
    endtask

    task automatic test_write_read;
        logic [31:0] rd;
        logic        er;
        int          ns, ne, lat;
        run_cmd(1'b1, 32'h4, 32'hDEAD_BEEF, rd, er, ns, ne, lat);
        n_vec++;
        if (ns !== 2 || ne !== 1 || lat !== 3) begin
            n_err++;
            $display("FAIL wr_timing: got sel=%0d en=%0d lat=%0d want 2 1 3",
                     ns, ne, lat);
        end
        n_vec++;
        if (rd !== 32'h0 || er !== 1'b0) begin
            n_err++;
            $display("FAIL wr_rsp: got %h err=%b want 0 err=0", rd, er);
        end
        n_vec++;
        if (PADDR !== 32'h4 || PWDATA !== 32'hDEAD_BEEF || PWRITE !== 1'b1) begin
            n_err++;
            $display("FAIL wr_hold: got %h %h %b want 4 deadbeef 1",
                     PADDR, PWDATA, PWRITE);
        end
        run_cmd(1'b0, 32'h4, 32'h0, rd, er, ns, ne, lat);
        n_vec++;
        if (rd !== 32'hDEAD_BEEF || er !== 1'b0 || lat !== 3) begin
            n_err++;
            $display("FAIL rd_rsp: got %h err=%b lat=%0d want deadbeef 0 3",
                     rd, er, lat);
        end
        @(negedge PCLK);
        n_vec++;
        if (rsp_valid !== 1'b0 || rsp_rdata !== 32'hDEAD_BEEF) begin
            n_err++;
            $display("FAIL rsp_pulse: got v=%b %h want 0 deadbeef",
                     rsp_valid, rsp_rdata);
        end
    endtask

    task automatic test_back_to_back;
        logic        tw [7];
        logic [31:0] ta [7];
        logic [31:0] td [7];
        logic [31:0] rd [7];
        logic        er [7];
        int          acc [7];
        int          na, nr, cyc;
        tw = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
        ta = '{32'h0, 32'h8, 32'hC, 32'h0, 32'h8, 32'hC, 32'h10};
        td = '{32'h11, 32'h22, 32'h33, 32'h0, 32'h0, 32'h0, 32'h0};
        na = 0;
        nr = 0;
        cyc = 0;
        cmd_valid = 1'b1;
        cmd_write = tw[0];
        cmd_addr  = ta[0];
        cmd_wdata = td[0];
        while (nr < 7 && cyc < 200) begin
            if (cmd_valid && cmd_ready && na < 7) begin
                acc[na] = cyc;
                na++;
            end
            @(posedge PCLK);
            @(negedge PCLK);
            cyc++;
            if (rsp_valid) begin
                rd[nr] = rsp_rdata;
                er[nr] = rsp_err;
                nr++;
            end
            if (na < 7) begin
                cmd_write = tw[na];
                cmd_addr  = ta[na];
                cmd_wdata = td[na];
            end else begin
                cmd_valid = 1'b0;
            end
        end
        cmd_valid = 1'b0;
        n_vec++;
        if (nr !== 7) begin
            n_err++;
            $display("FAIL b2b_count: got %0d responses want 7", nr);
        end
        for (int i = 0; i < 7; i++) begin
            n_vec++;
            if (acc[i] !== 3 * i) begin
                n_err++;
                $display("FAIL b2b_accept[%0d]: got cycle %0d want %0d",
                         i, acc[i], 3 * i);
            end
        end
        for (int i = 3; i < 7; i++) begin
            n_vec++;
            if (rd[i] !== ((i == 6) ? 32'h0 : td[i-3]) || er[i] !== 1'b0) begin
                n_err++;
                $display("FAIL b2b_read[%0d]: got %h err=%b want %h err=0",
                         i, rd[i], er[i], (i == 6) ? 32'h0 : td[i-3]);
            end
        end
    endtask

    task automatic test_wait_states;
        int          en, rs, cyc;
        logic        stable;
        logic [31:0] rd;
        slv_ready = 1'b0;
        cmd_valid = 1'b1;
        cmd_write = 1'b0;
        cmd_addr  = 32'h0;
        cmd_wdata = 32'h5555;
        @(posedge PCLK);
        @(negedge PCLK);
        cmd_valid = 1'b0;
        cmd_write = 1'b1;
        cmd_addr  = 32'hC;
        en = 0;
        rs = 0;
        cyc = 0;
        stable = 1'b1;
        rd = 32'hX;
        while (rs == 0 && cyc < 50) begin
            if (PSEL && (PADDR !== 32'h0 || PWRITE !== 1'b0)) stable = 1'b0;
            if (PENABLE) en++;
            if (en == 4) slv_ready = 1'b1;
            @(negedge PCLK);
            cyc++;
            if (rsp_valid) begin
                rs++;
                rd = rsp_rdata;
            end
        end
        @(negedge PCLK);
        if (rsp_valid) rs++;
        n_vec++;
        if (en !== 4 || stable !== 1'b1) begin
            n_err++;
            $display("FAIL ws_access: got en=%0d stable=%b want 4 1", en, stable);
        end
        n_vec++;
        if (rs !== 1 || rd !== 32'h11 || rsp_err !== 1'b0) begin
            n_err++;
            $display("FAIL ws_rsp: got n=%0d %h err=%b want 1 11 0",
                     rs, rd, rsp_err);
        end
    endtask

    task automatic test_timeout;
        logic [31:0] rd;
        logic        er;
        int          ns, ne, lat;
        slv_ready = 1'b0;
        run_cmd(1'b0, 32'h8, 32'h0, rd, er, ns, ne, lat);
        n_vec++;
        if (ne !== 16 || ns !== 17 || lat !== 18) begin
            n_err++;
            $display("FAIL to_len: got en=%0d sel=%0d lat=%0d want 16 17 18",
                     ne, ns, lat);
        end
        n_vec++;
        if (rd !== 32'h0 || er !== 1'b1) begin
            n_err++;
            $display("FAIL to_rsp: got %h err=%b want 0 err=1", rd, er);
        end
        slv_ready = 1'b1;
        run_cmd(1'b0, 32'h8, 32'h0, rd, er, ns, ne, lat);
        n_vec++;
        if (rd !== 32'h22 || er !== 1'b0 || lat !== 3) begin
            n_err++;
            $display("FAIL to_next: got %h err=%b lat=%0d want 22 0 3",
                     rd, er, lat);
        end
    endtask

    task automatic test_misaligned;
        logic [31:0] rd;
        logic        er;
        int          ns, ne, lat;
        run_cmd(1'b1, 32'h6, 32'hCAFE_0000, rd, er, ns, ne, lat);
        n_vec++;
        if (ns !== 0 || lat !== 2) begin
            n_err++;
            $display("FAIL mis_timing: got sel=%0d lat=%0d want 0 2", ns, lat);
        end
        n_vec++;
        if (rd !== 32'h0 || er !== 1'b1) begin
            n_err++;
            $display("FAIL mis_rsp: got %h err=%b want 0 err=1", rd, er);
        end
    endtask

    task automatic test_reset_mid;
        logic [31:0] rd;
        logic        er;
        int          ns, ne, lat, rs, cyc;
        slv_ready = 1'b0;
        cmd_valid = 1'b1;
        cmd_write = 1'b0;
        cmd_addr  = 32'hC;
        @(posedge PCLK);
        @(negedge PCLK);
        cmd_valid = 1'b0;
        cyc = 0;
        while (!PENABLE && cyc < 10) begin
            @(negedge PCLK);
            cyc++;
        end
        n_vec++;
        if (PENABLE !== 1'b1 || PSEL !== 1'b1) begin
            n_err++;
            $display("FAIL rm_access: got sel=%b en=%b want 1 1", PSEL, PENABLE);
        end
        #2;
        PRESETn = 1'b0;
        #1;
        n_vec++;
        if (PSEL !== 1'b0 || PENABLE !== 1'b0 || cmd_ready !== 1'b1) begin
            n_err++;
            $display("FAIL rm_async: got sel=%b en=%b rdy=%b want 0 0 1",
                     PSEL, PENABLE, cmd_ready);
        end
        @(negedge PCLK);
        PRESETn   = 1'b1;
        slv_ready = 1'b1;
        rs = 0;
        for (int i = 0; i < 4; i++) begin
            if (rsp_valid) rs++;
            @(negedge PCLK);
        end
        n_vec++;
        if (rs !== 0 || cmd_ready !== 1'b1) begin
            n_err++;
            $display("FAIL rm_norsp: got n=%0d rdy=%b want 0 1", rs, cmd_ready);
        end
        run_cmd(1'b0, 32'h0, 32'h0, rd, er, ns, ne, lat);
        n_vec++;
        if (rd !== 32'h0 || er !== 1'b0 || lat !== 3) begin
            n_err++;
            $display("FAIL rm_reg0: got %h err=%b lat=%0d want 0 0 3",
                     rd, er, lat);
        end
        run_cmd(1'b0, 32'h8, 32'h0, rd, er, ns, ne, lat);
        n_vec++;
        if (rd !== 32'h0 || er !== 1'b0) begin
            n_err++;
            $display("FAIL rm_reg8: got %h err=%b want 0 0", rd, er);
        end
    endtask

    initial begin
        test_reset();
        test_write_read();
        test_back_to_back();
        test_wait_states();
        test_timeout();
        test_misaligned();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
